id_ex_reg: RTL
==============

Name: id_ex_reg

Overview:
- Decode-to-execute pipeline register of the five-stage MIPS core.
- Sits directly downstream of the decode-stage immediate extender. Latches the 32-bit extended immediate (Ext_B_D) with the other decode-stage operands, and presents them to the EX stage as *_E signals.
- Supports hold (stall from EX), bubble insertion (flush from the hazard unit) and per-stage Tnew tracking for forwarding.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- TNEW_W, 2, width of the Tnew field.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low (sampled at posedge clk; 0 = reset)
- en  input  1  1 = load from D stage; 0 = hold current contents
- clr  input  1  1 = insert bubble (nop) at next edge
- Instr_D  input  32  decoded instruction word
- PC_D  input  32  instruction address
- RD1_D  input  32  forwarded rs operand
- RD2_D  input  32  forwarded rt operand
- Ext_B_D  input  32  extended immediate from extender
- Tnew_D  input  TNEW_W  cycles until result available, measured in D
- Instr_E  output  32  latched instruction
- PC_E  output  32  latched PC
- PC8_E  output  32  PC_E + 8 (link address for jal/jalr)
- RD1_E  output  32  latched rs operand
- RD2_E  output  32  latched rt operand
- Ext_E  output  32  latched extended immediate
- Tnew_E  output  TNEW_W  Tnew as seen in E
- Valid_E  output  1  1 = E holds a real instruction, 0 = bubble

Behaviour:
- All state updates on posedge clk only. Priority is reset > clr > en > hold.
- Reset (reset==0):
  - PC_E=RESET_PC, PC8_E=RESET_PC+8.
  - Instr_E, RD1_E, RD2_E, Ext_E, Tnew_E = 0; Valid_E=0.
- clr==1 (reset==1), regardless of en:
  - Instr_E=0 (sll $0,$0,0 nop); RD1_E=RD2_E=Ext_E=0; Tnew_E=0; Valid_E=0.
  - PC_E=PC_D, PC8_E=PC_D+8, so the bubble carries a meaningful PC for later exception/EPC logic.
- en==1, clr==0:
  - Load all *_D fields into the corresponding *_E registers; PC8_E=PC_D+8; Valid_E=1.
  - Tnew_E = (Tnew_D==0) ? 0 : Tnew_D-1. This is a saturating decrement, because one stage has elapsed.
- en==0, clr==0: every register holds its value, including Tnew_E; no decrement during hold.
- Latency: one cycle, D to E.
- PC8_E is registered, not combinational from PC_E. Addition wraps modulo 2^32 (PC_D=32'hFFFF_FFFC gives PC8_E=32'h0000_0004).
- Ext_E is an opaque 32-bit value: no re-extension or masking. Undefined (x) bits from the extender propagate unchanged.
- Reset asserted mid-stall, or simultaneously with clr/en: reset wins and the outputs take the reset values on that edge.
- Outputs are driven directly from registers; no combinational path from any input to any output.

Optional Feature:
- Macro: ID_EX_EXC_EN.
- When defined, add:
  - Inputs BD_D (1; instruction is in a branch delay slot) and ExcCode_D (5; pending exception code from F/D).
  - Outputs BD_E and ExcCode_E.
- Field behaviour with the macro defined:
  - Loaded with the other fields when en==1.
  - Held when en==0.
  - On clr: ExcCode_E=0 and BD_E=BD_D. Bubble replacing a delay-slot instruction keeps the BD flag so EPC = PC_E-4 stays correct.
  - On reset: both 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random D inputs -> PC_E=32'h0000_3000, PC8_E=32'h0000_3008, all other outputs 0, Valid_E=0.
- Normal load: reset=1, en=1, clr=0, PC_D=32'h0000_3010, Ext_B_D=32'hFFFF_8000, Tnew_D=2 -> next cycle Ext_E=32'hFFFF_8000, PC8_E=32'h0000_3018, Tnew_E=1, Valid_E=1; with Tnew_D=0 -> Tnew_E=0.
- Hold: load Instr_D=32'h3C01_1234, then en=0 for 3 cycles while changing D inputs -> Instr_E stays 32'h3C01_1234, Tnew_E unchanged.
- Flush over enable: en=1, clr=1, PC_D=32'h0000_3020 -> Instr_E=0, Valid_E=0, Tnew_E=0, PC_E=32'h0000_3020.
- Wrap and reset priority:
  - PC_D=32'hFFFF_FFFC, en=1 -> PC8_E=32'h0000_0004.
  - Then reset=0 with clr=1, en=1 on the same edge -> reset values.
- (With ID_EX_EXC_EN) BD_D=1, ExcCode_D=5'd10, clr=1 -> BD_E=1, ExcCode_E=0; with clr=0, en=1 -> ExcCode_E=5'd10.

Source files
------------

// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg -- decode-to-execute pipeline register of the five-stage MIPS core
//
// Latches the decode-stage operands (instruction, PC, forwarded rs/rt values,
// extended immediate and Tnew) and presents them to EX one cycle later.
// Priority on every rising edge: reset > clr > en > hold.
//
// Optional feature macro: ID_EX_EXC_EN
//   When defined, the branch-delay-slot flag (BD) and the pending exception
//   code (ExcCode) also travel through this stage.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous reset, active-low
//   en         1 = load from D, 0 = hold
//   clr        1 = insert a bubble at the next edge (overrides en)
//   Instr_D    decoded instruction word         -> Instr_E
//   PC_D       instruction address              -> PC_E, PC8_E (= PC + 8)
//   RD1_D      forwarded rs operand             -> RD1_E
//   RD2_D      forwarded rt operand             -> RD2_E
//   Ext_B_D    extended immediate               -> Ext_E
//   Tnew_D     result-ready countdown seen in D -> Tnew_E (aged by one stage)
//   BD_D       (macro) delay-slot flag          -> BD_E
//   ExcCode_D  (macro) pending exception code   -> ExcCode_E
//   Valid_E    1 = E holds a real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module id_ex_reg #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          TNEW_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              clr,
   input  logic [31:0]       Instr_D,
   input  logic [31:0]       PC_D,
   input  logic [31:0]       RD1_D,
   input  logic [31:0]       RD2_D,
   input  logic [31:0]       Ext_B_D,
   input  logic [TNEW_W-1:0] Tnew_D,
`ifdef ID_EX_EXC_EN
   input  logic              BD_D,
   input  logic [4:0]        ExcCode_D,
   output logic              BD_E,
   output logic [4:0]        ExcCode_E,
`endif
   output logic [31:0]       Instr_E,
   output logic [31:0]       PC_E,
   output logic [31:0]       PC8_E,
   output logic [31:0]       RD1_E,
   output logic [31:0]       RD2_E,
   output logic [31:0]       Ext_E,
   output logic [TNEW_W-1:0] Tnew_E,
   output logic              Valid_E
);

   // One pipeline stage elapses between D and E, so the countdown drops by
   // one, saturating at zero (a result already available stays available).
   function automatic logic [TNEW_W-1:0] tnew_age(input logic [TNEW_W-1:0] t);
      if (t == {TNEW_W{1'b0}}) begin
         return {TNEW_W{1'b0}};
      end else begin
         return t - TNEW_W'(1);
      end
   endfunction

   // Main pipeline register: reset > bubble > load; otherwise contents hold.
   // PC8_E is computed from PC_D here so the link address is registered;
   // the 32-bit add wraps naturally.
   always_ff @(posedge clk) begin
      if (!reset) begin
         Instr_E <= 32'h0000_0000;
         PC_E    <= RESET_PC;
         PC8_E   <= RESET_PC + 32'd8;
         RD1_E   <= 32'h0000_0000;
         RD2_E   <= 32'h0000_0000;
         Ext_E   <= 32'h0000_0000;
         Tnew_E  <= {TNEW_W{1'b0}};
         Valid_E <= 1'b0;
      end else if (clr) begin
         // Bubble is an all-zero word (sll $0,$0,0) but keeps the PC so
         // exception logic downstream still sees a sensible address.
         Instr_E <= 32'h0000_0000;
         PC_E    <= PC_D;
         PC8_E   <= PC_D + 32'd8;
         RD1_E   <= 32'h0000_0000;
         RD2_E   <= 32'h0000_0000;
         Ext_E   <= 32'h0000_0000;
         Tnew_E  <= {TNEW_W{1'b0}};
         Valid_E <= 1'b0;
      end else if (en) begin
         Instr_E <= Instr_D;
         PC_E    <= PC_D;
         PC8_E   <= PC_D + 32'd8;
         RD1_E   <= RD1_D;
         RD2_E   <= RD2_D;
         Ext_E   <= Ext_B_D;
         Tnew_E  <= tnew_age(Tnew_D);
         Valid_E <= 1'b1;
      end else begin
         // Stall: every field, Tnew included, keeps its value.
         Instr_E <= Instr_E;
         PC_E    <= PC_E;
         PC8_E   <= PC8_E;
         RD1_E   <= RD1_E;
         RD2_E   <= RD2_E;
         Ext_E   <= Ext_E;
         Tnew_E  <= Tnew_E;
         Valid_E <= Valid_E;
      end
   end

`ifdef ID_EX_EXC_EN
   // Exception side-band. A bubble drops the exception code but keeps the
   // delay-slot flag so EPC = PC_E - 4 stays correct for a flushed slot.
   always_ff @(posedge clk) begin
      if (!reset) begin
         BD_E      <= 1'b0;
         ExcCode_E <= 5'd0;
      end else if (clr) begin
         BD_E      <= BD_D;
         ExcCode_E <= 5'd0;
      end else if (en) begin
         BD_E      <= BD_D;
         ExcCode_E <= ExcCode_D;
      end else begin
         BD_E      <= BD_E;
         ExcCode_E <= ExcCode_E;
      end
   end
`endif

endmodule
